// File: rtl/icache_pkg.sv
// Shared types, constants and width helpers for the direct-mapped instruction cache.
package icache_pkg;

   typedef enum logic {IDLE, FETCH} state_t;

   localparam int LINE_BITS      = 128;
   localparam int WORDS_PER_LINE = 4;
   localparam int ADDR_W         = 30;

   function automatic int idx_w(input int lines);
      return $clog2(lines);
   endfunction

   // Word address minus the 2 offset bits and the index bits.
   function automatic int tag_w(input int lines);
      return ADDR_W - 2 - $clog2(lines);
   endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-port and refill-port signals of the instruction cache, bundled as one interface.
interface icache_if;
   import icache_pkg::*;

   logic                 proc_read;
   logic [ADDR_W-1:0]    proc_addr;
   logic [31:0]          proc_rdata;
   logic                 proc_stall;
   logic                 mem_read;
   logic [ADDR_W-3:0]    mem_addr;
   logic [LINE_BITS-1:0] mem_rdata;
   logic                 mem_ready;

   // Cache side.
   modport slave (
      input  proc_read, proc_addr, mem_rdata, mem_ready,
      output proc_rdata, proc_stall, mem_read, mem_addr
   );

   // Pipeline / memory environment side.
   modport master (
      output proc_read, proc_addr, mem_rdata, mem_ready,
      input  proc_rdata, proc_stall, mem_read, mem_addr
   );

endinterface

// File: rtl/icache_line_store.sv
// Valid, tag and data arrays: one synchronous write port, one combinational read port.
module icache_line_store
   import icache_pkg::*;
#(
   parameter int LINES = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        we,
   input  logic [idx_w(LINES)-1:0]     wr_idx,
   input  logic [tag_w(LINES)-1:0]     wr_tag,
   input  logic [LINE_BITS-1:0]        wr_line,
   input  logic [idx_w(LINES)-1:0]     rd_idx,
   output logic                        rd_vld,
   output logic [tag_w(LINES)-1:0]     rd_tag,
   output logic [LINE_BITS-1:0]        rd_line
);

   localparam int TW = tag_w(LINES);

   logic [LINES-1:0]     vld;
   logic [TW-1:0]        tag_arr  [LINES];
   logic [LINE_BITS-1:0] data_arr [LINES];

   // Data is cleared as well so the read port never returns X after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= '0;
         for (int i = 0; i < LINES; i++) begin
            tag_arr[i]  <= '0;
            data_arr[i] <= '0;
         end
      end else if (we) begin
         vld[wr_idx]      <= 1'b1;
         tag_arr[wr_idx]  <= wr_tag;
         data_arr[wr_idx] <= wr_line;
      end
   end

   assign rd_vld  = vld[rd_idx];
   assign rd_tag  = tag_arr[rd_idx];
   assign rd_line = data_arr[rd_idx];

endmodule

// File: rtl/icache.sv
// Read-only direct-mapped instruction cache: zero-latency hits, blocking line refill on miss.
module icache
   import icache_pkg::*;
#(
   parameter int LINES = 8
) (
   input  logic     clk,
   input  logic     rst,
   icache_if.slave  bus
);

   localparam int IW = idx_w(LINES);
   localparam int TW = tag_w(LINES);

   state_t              state, state_nx;
   logic [ADDR_W-1:2]   miss_addr;
   logic [1:0]          offset;
   logic [IW-1:0]       req_idx;
   logic [TW-1:0]       req_tag;
   logic                line_vld;
   logic [TW-1:0]       line_tag;
   logic [LINE_BITS-1:0] line_data;
   logic                hit;
   logic                refill_we;
   logic                miss_take;

   assign offset  = bus.proc_addr[1:0];
   assign req_idx = bus.proc_addr[IW+1:2];
   assign req_tag = bus.proc_addr[ADDR_W-1:IW+2];

   icache_line_store #(.LINES(LINES)) u_store (
      .clk     (clk),
      .rst     (rst),
      .we      (refill_we),
      .wr_idx  (miss_addr[IW+1:2]),
      .wr_tag  (miss_addr[ADDR_W-1:IW+2]),
      .wr_line (bus.mem_rdata),
      .rd_idx  (req_idx),
      .rd_vld  (line_vld),
      .rd_tag  (line_tag),
      .rd_line (line_data)
   );

   assign hit            = bus.proc_read & line_vld & (line_tag == req_tag);
   assign bus.proc_rdata = line_data[{offset, 5'd0} +: 32];
   assign bus.mem_addr   = miss_addr;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // A refill always runs to completion; fetch-side inputs are ignored in FETCH.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.proc_read && !hit) state_nx = FETCH;
         FETCH:   if (bus.mem_ready)         state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.mem_read   = 1'b0;
      bus.proc_stall = 1'b0;
      refill_we      = 1'b0;
      miss_take      = 1'b0;
      case (state)
         IDLE: begin
            bus.proc_stall = bus.proc_read & ~hit;
            miss_take      = bus.proc_read & ~hit;
         end
         FETCH: begin
            bus.mem_read   = 1'b1;
            bus.proc_stall = 1'b1;
            refill_we      = bus.mem_ready;
         end
         default: ;
      endcase
   end

   // Only the line address is kept; the word offset is re-read from proc_addr after refill.
   always_ff @(posedge clk) begin
      if (rst)            miss_addr <= '0;
      else if (miss_take) miss_addr <= bus.proc_addr[ADDR_W-1:2];
   end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, hits, conflict, redirect, reset mid-refill, idle.
module tb_icache;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   icache_if bus ();

   icache #(.LINES(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_of(input int la, input int k);
      return 32'hC000_0000 + 32'(la << 8) + 32'(k);
   endfunction

   function automatic logic [127:0] line_of(input int la);
      return {word_of(la, 3), word_of(la, 2), word_of(la, 1), word_of(la, 0)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.proc_read = 1'b0;
      bus.proc_addr = '0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      step();
      step();
      bus.proc_read = 1'b1;
      bus.proc_addr = 30'h5;
      #1;
      n_cmp++; if (bus.proc_stall !== 1'b1) begin n_err++; $display("FAIL rst_stall_read: got %b want 1", bus.proc_stall); end
      n_cmp++; if (bus.mem_read !== 1'b0) begin n_err++; $display("FAIL rst_mem_read: got %b want 0", bus.mem_read); end
      n_cmp++; if (bus.mem_addr !== 28'h0) begin n_err++; $display("FAIL rst_mem_addr: got %h want 0", bus.mem_addr); end
      bus.proc_read = 1'b0;
      #1;
      n_cmp++; if (bus.proc_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall_noread: got %b want 0", bus.proc_stall); end
      rst = 1'b0;
   endtask

   task automatic test_cold_miss();
      step();
      bus.proc_read = 1'b1;
      bus.proc_addr = 30'h5;
      #1;
      n_cmp++; if (bus.proc_stall !== 1'b1) begin n_err++; $display("FAIL cold_stall0: got %b want 1", bus.proc_stall); end
      n_cmp++; if (bus.mem_read !== 1'b0) begin n_err++; $display("FAIL cold_mem_read0: got %b want 0", bus.mem_read); end
      step();
      n_cmp++; if (bus.mem_read !== 1'b1) begin n_err++; $display("FAIL cold_mem_read1: got %b want 1", bus.mem_read); end
      n_cmp++; if (bus.mem_addr !== 28'h1) begin n_err++; $display("FAIL cold_mem_addr1: got %h want 1", bus.mem_addr); end
      n_cmp++; if (bus.proc_stall !== 1'b1) begin n_err++; $display("FAIL cold_stall1: got %b want 1", bus.proc_stall); end
      step();
      n_cmp++; if (bus.mem_addr !== 28'h1) begin n_err++; $display("FAIL cold_mem_addr2: got %h want 1", bus.mem_addr); end
      step();
      bus.mem_ready = 1'b1;
      bus.mem_rdata = line_of(1);
      #1;
      n_cmp++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 28'h1) begin n_err++; $display("FAIL cold_ready_cycle: got rd=%b addr=%h want rd=1 addr=1", bus.mem_read, bus.mem_addr); end
      step();
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      #1;
      n_cmp++; if (bus.proc_stall !== 1'b0) begin n_err++; $display("FAIL cold_hit_stall: got %b want 0", bus.proc_stall); end
      n_cmp++; if (bus.proc_rdata !== word_of(1, 1)) begin n_err++; $display("FAIL cold_hit_data: got %h want %h", bus.proc_rdata, word_of(1, 1)); end
      n_cmp++; if (bus.mem_read !== 1'b0) begin n_err++; $display("FAIL cold_mem_read_fall: got %b want 0", bus.mem_read); end
   endtask

   task automatic test_same_line();
      int addrs [3] = '{4, 6, 7};
      int ks    [3] = '{0, 2, 3};
      for (int i = 0; i < 3; i++) begin
         step();
         bus.proc_addr = 30'(addrs[i]);
         #1;
         n_cmp++; if (bus.proc_stall !== 1'b0 || bus.mem_read !== 1'b0) begin n_err++; $display("FAIL same_line_ctl[%0d]: got stall=%b rd=%b want 0 0", i, bus.proc_stall, bus.mem_read); end
         n_cmp++; if (bus.proc_rdata !== word_of(1, ks[i])) begin n_err++; $display("FAIL same_line_data[%0d]: got %h want %h", i, bus.proc_rdata, word_of(1, ks[i])); end
      end
   endtask

   task automatic test_conflict();
      step();
      bus.proc_addr = 30'h24;
      #1;
      n_cmp++; if (bus.proc_stall !== 1'b1) begin n_err++; $display("FAIL conflict_miss: got %b want 1", bus.proc_stall); end
      step();
      n_cmp++; if (bus.mem_addr !== 28'h9) begin n_err++; $display("FAIL conflict_mem_addr: got %h want 9", bus.mem_addr); end
      bus.mem_ready = 1'b1;
      bus.mem_rdata = line_of(9);
      step();
      bus.mem_ready = 1'b0;
      #1;
      n_cmp++; if (bus.proc_stall !== 1'b0 || bus.proc_rdata !== word_of(9, 0)) begin n_err++; $display("FAIL conflict_hit: got stall=%b data=%h want 0 %h", bus.proc_stall, bus.proc_rdata, word_of(9, 0)); end
      step();
      bus.proc_addr = 30'h4;
      #1;
      n_cmp++; if (bus.proc_stall !== 1'b1) begin n_err++; $display("FAIL conflict_reread_miss: got %b want 1", bus.proc_stall); end
      step();
      n_cmp++; if (bus.mem_addr !== 28'h1) begin n_err++; $display("FAIL conflict_reread_addr: got %h want 1", bus.mem_addr); end
      bus.mem_ready = 1'b1;
      bus.mem_rdata = line_of(1);
      step();
      bus.mem_ready = 1'b0;
      #1;
      n_cmp++; if (bus.proc_stall !== 1'b0 || bus.proc_rdata !== word_of(1, 0)) begin n_err++; $display("FAIL conflict_reread_hit: got stall=%b data=%h want 0 %h", bus.proc_stall, bus.proc_rdata, word_of(1, 0)); end
   endtask

   task automatic test_redirect();
      step();
      bus.proc_addr = 30'h10;
      #1;
      n_cmp++; if (bus.proc_stall !== 1'b1) begin n_err++; $display("FAIL redir_miss: got %b want 1", bus.proc_stall); end
      step();
      bus.proc_addr = 30'h40;
      #1;
      n_cmp++; if (bus.mem_addr !== 28'h4 || bus.proc_stall !== 1'b1) begin n_err++; $display("FAIL redir_fetch: got addr=%h stall=%b want 4 1", bus.mem_addr, bus.proc_stall); end
      step();
      bus.mem_ready = 1'b1;
      bus.mem_rdata = line_of(4);
      #1;
      n_cmp++; if (bus.mem_addr !== 28'h4 || bus.mem_read !== 1'b1) begin n_err++; $display("FAIL redir_stable: got addr=%h rd=%b want 4 1", bus.mem_addr, bus.mem_read); end
      step();
      bus.mem_ready = 1'b0;
      #1;
      n_cmp++; if (bus.proc_stall !== 1'b1 || bus.mem_read !== 1'b0) begin n_err++; $display("FAIL redir_new_miss: got stall=%b rd=%b want 1 0", bus.proc_stall, bus.mem_read); end
      step();
      n_cmp++; if (bus.mem_addr !== 28'h10 || bus.mem_read !== 1'b1) begin n_err++; $display("FAIL redir_new_addr: got addr=%h rd=%b want 10 1", bus.mem_addr, bus.mem_read); end
      bus.mem_ready = 1'b1;
      bus.mem_rdata = line_of(16);
      step();
      bus.mem_ready = 1'b0;
      #1;
      n_cmp++; if (bus.proc_stall !== 1'b0 || bus.proc_rdata !== word_of(16, 0)) begin n_err++; $display("FAIL redir_new_hit: got stall=%b data=%h want 0 %h", bus.proc_stall, bus.proc_rdata, word_of(16, 0)); end
      bus.proc_addr = 30'h10;
      #1;
      n_cmp++; if (bus.proc_stall !== 1'b0 || bus.proc_rdata !== word_of(4, 0)) begin n_err++; $display("FAIL redir_old_hit: got stall=%b data=%h want 0 %h", bus.proc_stall, bus.proc_rdata, word_of(4, 0)); end
   endtask

   task automatic test_reset_mid();
      step();
      bus.proc_addr = 30'h20;
      #1;
      n_cmp++; if (bus.proc_stall !== 1'b1) begin n_err++; $display("FAIL rmid_miss: got %b want 1", bus.proc_stall); end
      step();
      n_cmp++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 28'h8) begin n_err++; $display("FAIL rmid_fetch: got rd=%b addr=%h want 1 8", bus.mem_read, bus.mem_addr); end
      rst = 1'b1;
      bus.mem_ready = 1'b1;
      bus.mem_rdata = line_of(8);
      bus.proc_read = 1'b0;
      step();
      rst = 1'b0;
      bus.mem_ready = 1'b0;
      #1;
      n_cmp++; if (bus.mem_read !== 1'b0 || bus.proc_stall !== 1'b0 || bus.mem_addr !== 28'h0) begin n_err++; $display("FAIL rmid_idle: got rd=%b stall=%b addr=%h want 0 0 0", bus.mem_read, bus.proc_stall, bus.mem_addr); end
      step();
      bus.mem_ready = 1'b1;
      bus.mem_rdata = line_of(8);
      step();
      bus.mem_ready = 1'b0;
      bus.proc_read = 1'b1;
      bus.proc_addr = 30'h20;
      #1;
      n_cmp++; if (bus.proc_stall !== 1'b1) begin n_err++; $display("FAIL rmid_late_ready: got %b want 1", bus.proc_stall); end
      bus.proc_addr = 30'h10;
      #1;
      n_cmp++; if (bus.proc_stall !== 1'b1) begin n_err++; $display("FAIL rmid_0x10_miss: got %b want 1", bus.proc_stall); end
      bus.proc_addr = 30'h5;
      #1;
      n_cmp++; if (bus.proc_stall !== 1'b1) begin n_err++; $display("FAIL rmid_0x5_miss: got %b want 1", bus.proc_stall); end
      bus.proc_read = 1'b0;
   endtask

   task automatic test_idle();
      step();
      bus.proc_read = 1'b1;
      bus.proc_addr = 30'h8;
      step();
      bus.mem_ready = 1'b1;
      bus.mem_rdata = line_of(2);
      step();
      bus.mem_ready = 1'b0;
      #1;
      n_cmp++; if (bus.proc_stall !== 1'b0 || bus.proc_rdata !== word_of(2, 0)) begin n_err++; $display("FAIL idle_prefill: got stall=%b data=%h want 0 %h", bus.proc_stall, bus.proc_rdata, word_of(2, 0)); end
      bus.proc_read = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         bus.proc_addr = 30'($urandom);
         bus.mem_ready = (i == 4);
         bus.mem_rdata = '1;
         #1;
         n_cmp++; if (bus.proc_stall !== 1'b0 || bus.mem_read !== 1'b0) begin n_err++; $display("FAIL idle_cycle[%0d]: got stall=%b rd=%b want 0 0", i, bus.proc_stall, bus.mem_read); end
      end
      step();
      bus.mem_ready = 1'b0;
      bus.proc_read = 1'b1;
      bus.proc_addr = 30'h8;
      #1;
      n_cmp++; if (bus.proc_stall !== 1'b0 || bus.proc_rdata !== word_of(2, 0)) begin n_err++; $display("FAIL idle_data_kept: got stall=%b data=%h want 0 %h", bus.proc_stall, bus.proc_rdata, word_of(2, 0)); end
      bus.proc_addr = 30'h24;
      #1;
      n_cmp++; if (bus.proc_stall !== 1'b1) begin n_err++; $display("FAIL idle_no_spurious_fill: got %b want 1", bus.proc_stall); end
      bus.proc_read = 1'b0;
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_same_line();
      test_conflict();
      test_redirect();
      test_reset_mid();
      test_idle();
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
